nru_req_arbiter: RTL



---
 rtl/nru_req_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nru_req_arbiter.sv
// Two-domain request arbiter for the nru replacement block: one buffered request per
// domain, at most one os/user issue per cycle, and hit results routed back to the issuing domain.
module nru_req_arbiter #(
  parameter int NUM_WAYS    = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int HIT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_is_os,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*NUM_WAYS-1:0]   req_hitmap,
  output logic [1:0]              resp_valid,
  output logic [1:0]              resp_hit,
  output logic                    os_req,
  output logic [NUM_WAYS-1:0]     hitmap,
  output logic                    user_req,
  output logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    hit,
  output logic                    grant_dom
);

  // Handshake: a request moves on a clock edge where req_valid[d] && req_ready[d];
  // req_ready[d] depends only on the registered buffer state, never on req_valid.
  logic [1:0]            buf_valid;
  logic [1:0]            buf_os;
  logic [ADDR_WIDTH-1:0] buf_addr   [2];
  logic [NUM_WAYS-1:0]   buf_hitmap [2];
  logic                  rr;

  logic [1:0] os_full;
  logic [1:0] usr_full;
  logic [1:0] cand;
  logic       gnt_valid;
  logic       gnt_dom;
  logic       gnt_os;

  logic [HIT_LATENCY-1:0] pipe_v;
  logic [HIT_LATENCY-1:0] pipe_d;
  logic                   head_v;
  logic                   head_d;

  assign req_ready = ~buf_valid & {2{~reset}};
  assign head_v    = pipe_v[HIT_LATENCY-1];
  assign head_d    = pipe_d[HIT_LATENCY-1];

  // OS class first; inside the winning class the round-robin domain goes first.
  always_comb begin
    os_full   = buf_valid & buf_os;
    usr_full  = buf_valid & ~buf_os;
    cand      = (os_full != 2'b00) ? os_full : usr_full;
    gnt_valid = |cand;
    gnt_dom   = 1'b0;
    if (cand[rr]) begin
      gnt_dom = rr;
    end else if (cand[!rr]) begin
      gnt_dom = !rr;
    end
    gnt_os = buf_os[gnt_dom];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= '0;
      buf_os    <= '0;
      for (int d = 0; d < 2; d++) begin
        buf_addr[d]   <= '0;
        buf_hitmap[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        // Accept only happens into an empty buffer, and grant only from a full one.
        if (req_valid[d] && req_ready[d]) begin
          buf_valid[d]  <= 1'b1;
          buf_os[d]     <= req_is_os[d];
          buf_addr[d]   <= req_addr[d*ADDR_WIDTH +: ADDR_WIDTH];
          buf_hitmap[d] <= req_hitmap[d*NUM_WAYS +: NUM_WAYS];
        end else if (gnt_valid && (gnt_dom == d[0])) begin
          buf_valid[d] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_req    <= 1'b0;
      user_req  <= 1'b0;
      hitmap    <= '0;
      addr      <= '0;
      grant_dom <= 1'b0;
      rr        <= 1'b0;
    end else begin
      os_req   <= gnt_valid && gnt_os;
      user_req <= gnt_valid && !gnt_os;
      hitmap   <= (gnt_valid && gnt_os) ? buf_hitmap[gnt_dom] : '0;
      if (gnt_valid && !gnt_os) begin
        addr <= buf_addr[gnt_dom];
      end
      if (gnt_valid) begin
        grant_dom <= gnt_dom;
        rr        <= !gnt_dom;
      end
    end
  end

  // Stage 0 captures the visible user_req, so the head lines up with the nru hit cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_d <= '0;
    end else begin
      pipe_v[0] <= user_req;
      pipe_d[0] <= grant_dom;
      for (int i = 1; i < HIT_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= '0;
      resp_hit   <= '0;
    end else begin
      resp_valid <= '0;
      resp_hit   <= '0;
      if (head_v) begin
        resp_valid[head_d] <= 1'b1;
        resp_hit[head_d]   <= hit;
      end
    end
  end

endmodule
